// File: rtl/organ_pkg.sv
// -----------------------------------------------------------------------------
// organ_pkg
// Shared definitions for the note sequencer: the note/tone widths, the stored
// slot width, the rest value, and the sequencer state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package organ_pkg;

  localparam int NOTE_W = 3;
  localparam int TONE_W = 2;
  // One stored slot is {tone, note}.
  localparam int SLOT_W = NOTE_W + TONE_W;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // busy covers the two states that own a track.
  function automatic logic is_busy(input state_t s);
    return (s == S_REC) || (s == S_PLAY);
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// -----------------------------------------------------------------------------
// seq_tick_gen
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// The count ignores sequencer mode and restarts from 0 only on reset.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   tick_o  - high for one cycle when the count reaches TICK_DIV-1
// -----------------------------------------------------------------------------
module seq_tick_gen #(
  parameter int TICK_DIV = 6_250_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Multi-track note recorder/player. Each tick (every TICK_DIV clocks) REC
// stores {tone_in,value_in} into the latched track; PLAY presents one stored
// note per tick on value_out/tone_out, one clock after the tick.
//
// Optional feature: define NOTE_SEQUENCER_LOOP_EN to let loop=1 wrap playback
// back to the first note with no gap slot. Without it, loop is ignored.
//
// Ports:
//   clk        - system clock (rising edge)
//   rst        - asynchronous active-low reset (lengths, state, outputs, tick)
//   value_in   - live note (0 = rest)      tone_in  - live tone select
//   record     - level request to record   play     - level request to play
//   track_sel  - target track, latched on entry to REC/PLAY
//   loop       - repeat playback (LOOP_EN builds only)
//   value_out  - played note               tone_out - played tone
//   busy       - high in REC or PLAY
//   full       - selected/active track holds DEPTH notes
//   rec_len    - stored length of the active track (track_sel in IDLE)
//   state_o    - current FSM state, for observation
//
// record and play are plain levels sampled every clock: there is no handshake;
// record wins over play, and dropping play or record is acted on at the next
// clock edge.
// -----------------------------------------------------------------------------
module note_sequencer
  import organ_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 6_250_000
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NOTE_W-1:0]                              value_in,
  input  logic [TONE_W-1:0]                              tone_in,
  input  logic                                           record,
  input  logic                                           play,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] track_sel,
  input  logic                                           loop,
  output logic [NOTE_W-1:0]                              value_out,
  output logic [TONE_W-1:0]                              tone_out,
  output logic                                           busy,
  output logic                                           full,
  output logic [$clog2(DEPTH):0]                         rec_len,
  output state_t                                         state_o
);

  localparam int TW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW        = $clog2(DEPTH);
  localparam int LW        = PW + 1;
  localparam int AW        = TW + PW;
  localparam int MEM_WORDS = CHANNELS * DEPTH;
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  logic tick;

  seq_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [TW-1:0]     trk_q;
  logic [LW-1:0]     ptr_q;
  logic [SLOT_W-1:0] slot_q;
  logic [LW-1:0]     len_q [CHANNELS];

  // Track storage: not reset; a zero length makes old contents unreachable.
  logic [SLOT_W-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Loop option
  // ---------------------------------------------------------------------------
  logic loop_active;
`ifdef NOTE_SEQUENCER_LOOP_EN
  assign loop_active = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [TW-1:0]     sel_eff;
  logic [TW-1:0]     act_trk;
  logic [LW-1:0]     cur_len;
  logic              at_end;
  logic [PW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     wr_addr;
  logic [SLOT_W-1:0] rd_data;
  logic              wr_en;

  always_comb begin
    // Out-of-range selections (non power-of-two CHANNELS) fall back to track 0.
    sel_eff = ({1'b0, track_sel} < (TW + 1)'(CHANNELS)) ? track_sel : '0;
    // The latched track is the active one except in IDLE, where the live
    // selection is reported.
    act_trk = (state_q == S_IDLE) ? sel_eff : trk_q;
    cur_len = len_q[trk_q];
    at_end  = (ptr_q == cur_len);
    // At the end of the track the read address already points at note 0 so a
    // loop wrap can present it on the same tick with no gap slot.
    rd_ptr  = at_end ? '0 : ptr_q[PW-1:0];
    rd_addr = {trk_q, rd_ptr};
    wr_addr = {trk_q, cur_len[PW-1:0]};
    wr_en   = (state_q == S_REC) && record && tick && (cur_len != FULL_LEN);
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {tone_in, value_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      trk_q   <= '0;
      ptr_q   <= '0;
      slot_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          slot_q <= '0;
          if (record) begin
            state_q        <= S_REC;
            trk_q          <= sel_eff;
            len_q[sel_eff] <= '0;
          end else if (play) begin
            state_q <= S_PLAY;
            trk_q   <= sel_eff;
            ptr_q   <= '0;
          end
        end

        S_REC: begin
          slot_q <= '0;
          if (!record) begin
            state_q <= S_IDLE;
          end else if (wr_en) begin
            len_q[trk_q] <= len_q[trk_q] + 1'b1;
          end
        end

        S_PLAY: begin
          if (record) begin
            state_q        <= S_REC;
            trk_q          <= sel_eff;
            len_q[sel_eff] <= '0;
            slot_q         <= '0;
          end else if (!play) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
          end else if (cur_len == '0) begin
            state_q <= S_HOLD;
            slot_q  <= '0;
          end else if (tick) begin
            if (!at_end) begin
              slot_q <= rd_data;
              ptr_q  <= ptr_q + 1'b1;
            end else if (loop_active) begin
              slot_q <= rd_data;
              ptr_q  <= LW'(1);
            end else begin
              state_q <= S_HOLD;
              slot_q  <= '0;
            end
          end
        end

        S_HOLD: begin
          slot_q <= '0;
          if (record) begin
            state_q        <= S_REC;
            trk_q          <= sel_eff;
            len_q[sel_eff] <= '0;
          end else if (!play) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          slot_q  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign value_out = slot_q[NOTE_W-1:0];
  assign tone_out  = slot_q[SLOT_W-1:NOTE_W];
  assign busy      = is_busy(state_q);
  assign rec_len   = len_q[act_trk];
  assign full      = (len_q[act_trk] == FULL_LEN);
  assign state_o   = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Self-checking bench for note_sequencer (CHANNELS=2, DEPTH=8, TICK_DIV=4).
// Directed vector table, hand-written corner sequences, then randomized
// record/play sessions checked against per-track note queues.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
  import organ_pkg::*;

  localparam int CH = 2;
  localparam int DP = 8;
  localparam int TD = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] value_in  = '0;
  logic [1:0] tone_in   = '0;
  logic       record    = 1'b0;
  logic       play      = 1'b0;
  logic       loop      = 1'b0;
  logic       track_sel = 1'b0;
  logic [2:0] value_out;
  logic [1:0] tone_out;
  logic       busy;
  logic       full;
  logic [3:0] rec_len;
  state_t     state_o;

  always #5 clk = ~clk;

  note_sequencer #(
    .CHANNELS (CH),
    .DEPTH    (DP),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .tone_in   (tone_in),
    .record    (record),
    .play      (play),
    .track_sel (track_sel),
    .loop      (loop),
    .value_out (value_out),
    .tone_out  (tone_out),
    .busy      (busy),
    .full      (full),
    .rec_len   (rec_len),
    .state_o   (state_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned edge_n   = 0;   // clock edges since reset release
  logic [4:0]  exp_q[$];
  logic [4:0]  model_trk[CH][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input state_t st, input logic [4:0] slot,
                               input logic bsy, input logic ful, input logic [3:0] len);
    check({name, "/state"}, 32'(state_o), 32'(st));
    check({name, "/slot"}, {27'd0, tone_out, value_out}, {27'd0, slot});
    check({name, "/busy"}, 32'(busy), 32'(bsy));
    check({name, "/full"}, 32'(full), 32'(ful));
    check({name, "/rec_len"}, 32'(rec_len), 32'(len));
  endtask

  task automatic check_play(input string name, input state_t st, input logic [4:0] slot);
    check({name, "/state"}, 32'(state_o), 32'(st));
    check({name, "/slot"}, {27'd0, tone_out, value_out}, {27'd0, slot});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge, outputs sampled there)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    if (rst) edge_n++;
    @(negedge clk);
  endtask

  // Run until the edge just taken was a tick edge (every TD-th after release).
  task automatic to_tick();
    do cycle(); while (edge_n % TD != 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    for (int t = 0; t < CH; t++) model_trk[t].delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rec;
    logic       ply;
    logic       sel;
    logic [2:0] val;
    logic       tck;
    state_t     st;
    logic [4:0] slot;
    logic       bsy;
    logic       ful;
    logic [3:0] len;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n_ent;
    int t_p;
    int n_rec;
    logic [4:0] e;

    // Reset
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_outputs("reset", S_IDLE, 5'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;

    // Record 1,2,3 on track 0, then play it back through to HOLD.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, S_REC,  5'd0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, S_REC,  5'd0, 1'b1, 1'b0, 4'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, S_REC,  5'd0, 1'b1, 1'b0, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, S_REC,  5'd0, 1'b1, 1'b0, 4'd3};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, S_IDLE, 5'd0, 1'b0, 1'b0, 4'd3};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, S_PLAY, 5'd0, 1'b1, 1'b0, 4'd3};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, S_PLAY, 5'd1, 1'b1, 1'b0, 4'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, S_PLAY, 5'd2, 1'b1, 1'b0, 4'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, S_PLAY, 5'd3, 1'b1, 1'b0, 4'd3};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, S_HOLD, 5'd0, 1'b0, 1'b0, 4'd3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, S_HOLD, 5'd0, 1'b0, 1'b0, 4'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, S_IDLE, 5'd0, 1'b0, 1'b0, 4'd3};

    for (int i = 0; i < 12; i++) begin
      record    = tbl[i].rec;
      play      = tbl[i].ply;
      track_sel = tbl[i].sel;
      value_in  = tbl[i].val;
      tone_in   = 2'd0;
      if (tbl[i].tck) to_tick(); else cycle();
      check_outputs($sformatf("vec%0d", i), tbl[i].st, tbl[i].slot, tbl[i].bsy, tbl[i].ful, tbl[i].len);
    end

    // Overfill track 1: full after the 8th write, no wrap over address 0.
    track_sel = 1'b1;
    record = 1'b1;
    cycle();
    check_outputs("fill_entry", S_REC, 5'd0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      value_in = 3'((i % 7) + 1);
      tone_in  = 2'(i % 4);
      to_tick();
      check($sformatf("fill%0d/rec_len", i), 32'(rec_len), (i + 1 < DP) ? 32'(i + 1) : 32'(DP));
      check($sformatf("fill%0d/full", i), 32'(full), (i + 1 >= DP) ? 32'd1 : 32'd0);
    end
    record = 1'b0;
    cycle();
    check_outputs("fill_idle", S_IDLE, 5'd0, 1'b0, 1'b1, 4'd8);
    play = 1'b1;
    cycle();
    to_tick();
    check_play("fill_note0", S_PLAY, 5'(((0 % 4) << 3) | ((0 % 7) + 1)));
    to_tick();
    check_play("fill_note1", S_PLAY, 5'(((1 % 4) << 3) | ((1 % 7) + 1)));
    play = 1'b0;
    cycle();
    check_outputs("play_drop", S_IDLE, 5'd0, 1'b0, 1'b1, 4'd8);

    // track_sel change mid-record stays on the latched track.
    reset_dut();
    track_sel = 1'b0;
    record = 1'b1;
    tone_in = 2'd0;
    cycle();
    value_in = 3'd4;
    to_tick();
    track_sel = 1'b1;
    value_in = 3'd5;
    to_tick();
    check("sel_mid/rec_len", 32'(rec_len), 32'd2);
    record = 1'b0;
    cycle();
    #1;
    check("sel_trk1/rec_len", 32'(rec_len), 32'd0);
    track_sel = 1'b0;
    #1;
    check("sel_trk0/rec_len", 32'(rec_len), 32'd2);
    track_sel = 1'b1;
    play = 1'b1;
    cycle();
    check_play("empty_play", S_PLAY, 5'd0);
    cycle();
    check_outputs("empty_hold", S_HOLD, 5'd0, 1'b0, 1'b0, 4'd0);
    play = 1'b0;
    cycle();
    check_play("empty_idle", S_IDLE, 5'd0);

    // Two-note track 0 (4,5) played with loop requested.
    track_sel = 1'b0;
    loop = 1'b1;
    play = 1'b1;
    cycle();
    for (int j = 0; j < 4; j++) begin
      to_tick();
`ifdef NOTE_SEQUENCER_LOOP_EN
      check_play($sformatf("loop%0d", j), S_PLAY, (j % 2 == 0) ? 5'd4 : 5'd5);
`else
      if (j < 2) check_play($sformatf("loop%0d", j), S_PLAY, (j == 0) ? 5'd4 : 5'd5);
      else       check_play($sformatf("loop%0d", j), S_HOLD, 5'd0);
`endif
    end
    play = 1'b0;
    loop = 1'b0;
    cycle();
    check_play("loop_idle", S_IDLE, 5'd0);

    // Record asserted mid-play aborts into REC with a fresh length.
    play = 1'b1;
    cycle();
    to_tick();
    check_play("abort_note", S_PLAY, 5'd4);
    record = 1'b1;
    cycle();
    check_outputs("abort_rec", S_REC, 5'd0, 1'b1, 1'b0, 4'd0);
    record = 1'b0;
    play = 1'b0;
    cycle();
    check_outputs("abort_idle", S_IDLE, 5'd0, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset mid-play.
    record = 1'b1;
    cycle();
    value_in = 3'd6;
    to_tick();
    value_in = 3'd7;
    to_tick();
    record = 1'b0;
    cycle();
    play = 1'b1;
    cycle();
    to_tick();
    check_play("prerst_note", S_PLAY, 5'd6);
    rst = 1'b0;
    #1;
    check_outputs("async_rst", S_IDLE, 5'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    for (int t = 0; t < CH; t++) model_trk[t].delete();
    cycle();
    check_play("post_rst_play", S_PLAY, 5'd0);
    cycle();
    check_outputs("post_rst_hold", S_HOLD, 5'd0, 1'b0, 1'b0, 4'd0);
    play = 1'b0;
    cycle();

    // Randomized record/play sessions against per-track note queues.
    for (int it = 0; it < 12; it++) begin
      t_p = $urandom_range(0, CH - 1);
      n_rec = $urandom_range(0, 11);
      track_sel = 1'(t_p);
      record = 1'b1;
      cycle();
      model_trk[t_p].delete();
      for (int k = 0; k < n_rec; k++) begin
        value_in = 3'($urandom_range(0, 7));
        tone_in  = 2'($urandom_range(0, 3));
        to_tick();
        if (model_trk[t_p].size() < DP) model_trk[t_p].push_back({tone_in, value_in});
      end
      record = 1'b0;
      cycle();
      check($sformatf("rnd%0d/rec_len", it), 32'(rec_len), 32'(model_trk[t_p].size()));
      check($sformatf("rnd%0d/full", it), 32'(full), (model_trk[t_p].size() == DP) ? 32'd1 : 32'd0);

      t_p = $urandom_range(0, CH - 1);
      track_sel = 1'(t_p);
      play = 1'b1;
      cycle();
      exp_q = model_trk[t_p];
      n_ent = exp_q.size();
      if (n_ent == 0) begin
        cycle();
        check_play($sformatf("rnd%0d/empty", it), S_HOLD, 5'd0);
      end else begin
        for (int k = 0; k < n_ent; k++) begin
          to_tick();
          e = exp_q.pop_front();
          check_play($sformatf("rnd%0d/note%0d", it, k), S_PLAY, e);
        end
        to_tick();
        check_play($sformatf("rnd%0d/end", it), S_HOLD, 5'd0);
      end
      play = 1'b0;
      cycle();
      check_play($sformatf("rnd%0d/idle", it), S_IDLE, 5'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
